// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button pulse generator:
//   - btn_state_t   : FSM state encoding
//   - btn_cnt_width : width needed by the debounce/hold/repeat counters, so
//                     every counter can hold (largest parameter - 1)
// ---------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PRESS_WAIT   = 3'd1,
        ST_HELD         = 3'd2,
        ST_REPEAT       = 3'd3,
        ST_RELEASE_WAIT = 3'd4
    } btn_state_t;

    // Width of a counter that must reach (max(deb, hold, rep) - 1).
    // Never returns less than 1 so the counters always have a real bit.
    function automatic int btn_cnt_width(input int deb, input int hold, input int rep);
        int max_v;
        max_v = deb;
        max_v = (hold > max_v) ? hold : max_v;
        max_v = (rep > max_v) ? rep : max_v;
        return (max_v < 32'sd2) ? 32'sd1 : int'($clog2(max_v));
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Single-bit two-flop synchronizer for bringing an asynchronous input into
// the clk domain. Both flops reset asynchronously to 0.
// Ports:
//   clk_i  - destination clock
//   rst_i  - asynchronous active-high reset
//   d_i    - asynchronous input
//   q_o    - synchronized output (two clk edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage shift register; meta_q may go metastable, sync_q is clean.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_pulse_gen.sv
// ---------------------------------------------------------------------------
// btn_pulse_gen
// Turns a raw, bouncy, asynchronous push-button into clean one-cycle enable
// pulses, with optional auto-repeat while the button is held, and exports the
// debounced button level.
// Parameters:
//   DEBOUNCE_CYCLES - stable synchronized samples to accept press/release (>=2)
//   HOLD_CYCLES     - cycles in HELD after the first pulse before repeating (>=2)
//   REPEAT_CYCLES   - auto-repeat pulse period (>=2)
//   REPEAT_EN       - 1: auto-repeat on long hold, 0: one pulse per press
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   btn_in    - raw button, asynchronous to clk, may bounce
//   pulse_out - registered single-cycle enable pulse
//   btn_level - registered debounced button level
// ---------------------------------------------------------------------------
module btn_pulse_gen
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 8,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse_out,
    output logic btn_level
);

    localparam int CNT_W = btn_cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    // Reject parameter values too small for the counting scheme.
    if ((DEBOUNCE_CYCLES < 32'sd2) || (HOLD_CYCLES < 32'sd2) || (REPEAT_CYCLES < 32'sd2)) begin : g_param_check
        $error("btn_pulse_gen: DEBOUNCE_CYCLES, HOLD_CYCLES and REPEAT_CYCLES must all be >= 2");
    end

    logic             btn_s;
    btn_state_t       state_q,    state_d;
    logic [CNT_W-1:0] db_cnt_q,   db_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q,  rep_cnt_d;
    logic             pulse_q,    pulse_d;
    logic             level_q,    level_d;
    logic             db_inc_s;
    logic             hold_inc_s;
    logic             rep_inc_s;
    logic             entry_s;

    sync_2ff u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (btn_in),
        .q_o   (btn_s)
    );

    // Next-state logic; also decides which counter advances and when to pulse.
    always_comb begin
        state_d    = state_q;
        pulse_d    = 1'b0;
        db_inc_s   = 1'b0;
        hold_inc_s = 1'b0;
        rep_inc_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d = ST_PRESS_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_s) begin
                    // Glitch: back to idle without any output activity.
                    state_d = ST_IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = ST_HELD;
                    pulse_d = 1'b1;
                end else begin
                    db_inc_s = 1'b1;
                end
            end
            ST_HELD: begin
                if (!btn_s) begin
                    state_d = ST_RELEASE_WAIT;
                end else if (REPEAT_EN && (hold_cnt_q == HOLD_LAST)) begin
                    state_d = ST_REPEAT;
                    pulse_d = 1'b1;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_inc_s = 1'b1;
                end else begin
                    // Without auto-repeat the hold timer simply saturates.
                    hold_inc_s = 1'b0;
                end
            end
            ST_REPEAT: begin
                if (!btn_s) begin
                    // Release wins: a pulse due on this cycle is dropped.
                    state_d = ST_RELEASE_WAIT;
                end else if (rep_cnt_q == REP_LAST) begin
                    pulse_d   = 1'b1;
                    rep_inc_s = 1'b1;
                end else begin
                    rep_inc_s = 1'b1;
                end
            end
            ST_RELEASE_WAIT: begin
                if (btn_s) begin
                    // Release bounce: resume holding, hold timer restarts.
                    state_d = ST_HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    db_inc_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter next values; every state change clears all counters.
    always_comb begin
        entry_s = (state_d != state_q);
        if (entry_s) begin
            db_cnt_d   = '0;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
        end else begin
            db_cnt_d   = db_inc_s   ? (db_cnt_q + CNT_W'(1))   : db_cnt_q;
            hold_cnt_d = hold_inc_s ? (hold_cnt_q + CNT_W'(1)) : hold_cnt_q;
            if (rep_inc_s) begin
                rep_cnt_d = (rep_cnt_q == REP_LAST) ? '0 : (rep_cnt_q + CNT_W'(1));
            end else begin
                rep_cnt_d = rep_cnt_q;
            end
        end
    end

    // Debounced level is high whenever the next state is a "pressed" state.
    always_comb begin
        case (state_d)
            ST_HELD, ST_REPEAT, ST_RELEASE_WAIT: level_d = 1'b1;
            ST_IDLE, ST_PRESS_WAIT:              level_d = 1'b0;
            default:                             level_d = 1'b0;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            pulse_q    <= 1'b0;
            level_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            pulse_q    <= pulse_d;
            level_q    <= level_d;
        end
    end

    assign pulse_out = pulse_q;
    assign btn_level = level_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_btn_pulse_gen
// Directed bench for btn_pulse_gen with DEBOUNCE=4, HOLD=16, REPEAT=4.
// A second instance with REPEAT_EN=0 shares the button input. A 5-bit
// counter driven by pulse_out stands in for the downstream counter.
// Timing convention: inputs change 1 time unit after a rising edge; if that
// happens when cyc==B, the next rising edge (edge 0) raises cyc to B+1, and a
// pulse registered at edge k is logged with cyc == B+1+k.
// ---------------------------------------------------------------------------
module tb_btn_pulse_gen;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic pulse_out, btn_level;
    logic pulse_nr, level_nr;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    btn_pulse_gen #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (16),
        .REPEAT_CYCLES   (4),
        .REPEAT_EN       (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .pulse_out (pulse_out),
        .btn_level (btn_level)
    );

    btn_pulse_gen #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (16),
        .REPEAT_CYCLES   (4),
        .REPEAT_EN       (1'b0)
    ) dut_nr (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .pulse_out (pulse_nr),
        .btn_level (level_nr)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Event logs, sampled on the falling edge.
    int unsigned pulse_log[$];
    int unsigned nr_log[$];
    int unsigned rise_log[$];
    int unsigned fall_log[$];
    int unsigned consec_cnt = 0;
    logic        prev_pulse = 1'b0;
    logic        prev_level = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_pulse <= 1'b0;
            prev_level <= 1'b0;
        end else begin
            if (pulse_out) pulse_log.push_back(cyc);
            if (pulse_nr)  nr_log.push_back(cyc);
            if (btn_level && !prev_level) rise_log.push_back(cyc);
            if (!btn_level && prev_level) fall_log.push_back(cyc);
            if (pulse_out && prev_pulse) consec_cnt <= consec_cnt + 32'd1;
            prev_pulse <= pulse_out;
            prev_level <= btn_level;
        end
    end

    // Downstream 5-bit enable-gated counter.
    logic [4:0] cnt5;
    logic       cnt_clr;
    logic       wrapped;
    always @(posedge clk) begin
        if (cnt_clr) begin
            cnt5    <= 5'd0;
            wrapped <= 1'b0;
        end else if (pulse_out) begin
            cnt5 <= cnt5 + 5'd1;
            if (cnt5 == 5'd31) wrapped <= 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        pulse_log.delete();
        nr_log.delete();
        rise_log.delete();
        fall_log.delete();
    endtask

    // Expected pulses for a clean press held for hold_len input samples:
    // the FSM sees the button at edges 2..hold_len+1; pulses at edge 6,
    // then edge 22 and every 4 edges after that.
    function automatic int exp_pulses(input int hold_len);
        int last_e;
        int n;
        last_e = hold_len + 1;
        n = (last_e >= 6) ? 1 : 0;
        for (int e = 22; e <= last_e; e += 4) n++;
        return n;
    endfunction

    int unsigned base;
    int unsigned rel;

    initial begin
        rst     = 1'b1;
        btn_in  = 1'b0;
        cnt_clr = 1'b1;
        tick(3);
        check_eq("rst_pulse", 32'(pulse_out), 32'd0);
        check_eq("rst_level", 32'(btn_level), 32'd0);
        check_eq("rst_pulse_nr", 32'(pulse_nr), 32'd0);
        rst = 1'b0;
        tick(2);
        cnt_clr = 1'b0;

        // Clean press: 10 cycles high, then release.
        clear_logs();
        base = cyc;
        btn_in = 1'b1;
        tick(10);
        rel = cyc;
        btn_in = 1'b0;
        tick(12);
        check_eq("clean_npulse", 32'(pulse_log.size()), 32'd1);
        if (pulse_log.size() > 0) check_eq("clean_ptime", pulse_log[0], base + 32'd7);
        check_eq("clean_nrise", 32'(rise_log.size()), 32'd1);
        if (rise_log.size() > 0) check_eq("clean_rise", rise_log[0], base + 32'd7);
        check_eq("clean_nfall", 32'(fall_log.size()), 32'd1);
        if (fall_log.size() > 0) check_eq("clean_fall", fall_log[0], rel + 32'd7);
        check_eq("clean_level_end", 32'(btn_level), 32'd0);

        // Bounce reject: 3 high / 1 low, five times.
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            btn_in = 1'b1;
            tick(3);
            btn_in = 1'b0;
            tick(1);
        end
        tick(10);
        check_eq("bounce_npulse", 32'(pulse_log.size()), 32'd0);
        check_eq("bounce_nrise", 32'(rise_log.size()), 32'd0);
        check_eq("bounce_level", 32'(btn_level), 32'd0);

        // Auto-repeat: hold 60 cycles. Pulses at edges 6, 22, 26 ... 58.
        clear_logs();
        base = cyc;
        btn_in = 1'b1;
        tick(60);
        rel = cyc;
        btn_in = 1'b0;
        tick(14);
        check_eq("rep_npulse", 32'(pulse_log.size()), 32'(exp_pulses(60)));
        check_eq("rep_npulse_hand", 32'(pulse_log.size()), 32'd11);
        if (pulse_log.size() >= 3) begin
            check_eq("rep_p0", pulse_log[0], base + 32'd7);
            check_eq("rep_p1", pulse_log[1], base + 32'd23);
            check_eq("rep_p2", pulse_log[2], base + 32'd27);
            check_eq("rep_plast", pulse_log[pulse_log.size()-1], base + 32'd59);
        end
        if (fall_log.size() > 0) check_eq("rep_fall", fall_log[0], rel + 32'd7);
        check_eq("rep_nfall", 32'(fall_log.size()), 32'd1);

        // Release bounce in HELD, then a due repeat suppressed by release.
        clear_logs();
        base = cyc;
        btn_in = 1'b1;
        tick(10);
        btn_in = 1'b0;
        tick(2);
        btn_in = 1'b1;
        tick(24);
        check_eq("rb_level_held", 32'(btn_level), 32'd1);
        check_eq("rb_nfall_held", 32'(fall_log.size()), 32'd0);
        btn_in = 1'b0;
        tick(14);
        check_eq("rb_npulse", 32'(pulse_log.size()), 32'd3);
        if (pulse_log.size() >= 3) begin
            check_eq("rb_p0", pulse_log[0], base + 32'd7);
            check_eq("rb_p1", pulse_log[1], base + 32'd31);
            check_eq("rb_p2", pulse_log[2], base + 32'd35);
        end
        check_eq("rb_nrise", 32'(rise_log.size()), 32'd1);
        check_eq("rb_nfall", 32'(fall_log.size()), 32'd1);
        if (fall_log.size() > 0) check_eq("rb_fall", fall_log[0], base + 32'd43);

        // REPEAT_EN=0 instance: one pulse on a 100-cycle hold.
        clear_logs();
        base = cyc;
        btn_in = 1'b1;
        tick(100);
        check_eq("norep_level", 32'(level_nr), 32'd1);
        btn_in = 1'b0;
        tick(14);
        check_eq("norep_npulse", 32'(nr_log.size()), 32'd1);
        if (nr_log.size() > 0) check_eq("norep_ptime", nr_log[0], base + 32'd7);
        check_eq("norep_rep_npulse", 32'(pulse_log.size()), 32'd21);
        check_eq("norep_level_end", 32'(level_nr), 32'd0);

        // Reset asserted while a repeat pulse is high.
        clear_logs();
        base = cyc;
        btn_in = 1'b1;
        tick(27);
        check_eq("prerst_pulse", 32'(pulse_out), 32'd1);
        check_eq("prerst_level", 32'(btn_level), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("midrst_pulse", 32'(pulse_out), 32'd0);
        check_eq("midrst_level", 32'(btn_level), 32'd0);
        tick(3);
        rst = 1'b0;
        clear_logs();
        base = cyc;
        tick(14);
        check_eq("postrst_npulse", 32'(pulse_log.size()), 32'd1);
        if (pulse_log.size() > 0) check_eq("postrst_ptime", pulse_log[0], base + 32'd7);
        btn_in = 1'b0;
        tick(12);

        // Counter chain: three clean presses.
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_in = 1'b1;
            tick(10);
            btn_in = 1'b0;
            tick(12);
        end
        check_eq("chain_cnt3", 32'(cnt5), 32'd3);

        // Counter chain: 33 repeat pulses wrap 31 -> 0 -> 1.
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        clear_logs();
        btn_in = 1'b1;
        tick(145);
        btn_in = 1'b0;
        tick(14);
        check_eq("wrap_npulse", 32'(pulse_log.size()), 32'd33);
        check_eq("wrap_cnt", 32'(cnt5), 32'd1);
        check_eq("wrap_seen", 32'(wrapped), 32'd1);

        check_eq("no_consec_pulse", consec_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
